// File: rtl/mio_bus_ctrl_if.sv
// CPU data-side bus between the MEM stage (master) and the MMIO controller (slave).
interface mio_bus_ctrl_if;
    logic        MemRW;
    logic [3:0]  wea;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic [31:0] Data_in;

    modport master (output MemRW, wea, Addr_out, Data_out, input Data_in);
    modport slave  (input MemRW, wea, Addr_out, Data_out, output Data_in);
endinterface

// File: rtl/mio_bus_ctrl.sv
// Memory-mapped I/O controller: decodes CPU data accesses to RAM, LED/switch port, 7-seg register
// and an optional down-counter timer (present when macro COUNTER_EN is defined).
module mio_bus_ctrl #(
    parameter int unsigned RAM_ADDR_W = 10,
    parameter int unsigned PRESCALE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mio_bus_ctrl_if.slave         bus,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [3:0]            ram_wea,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout,
    input  logic [15:0]           sw,
    input  logic [3:0]            btn,
    output logic [15:0]           led,
    output logic [31:0]           disp_data,
    output logic                  counter_irq
);

    localparam logic [31:0] ADDR_DISP = 32'hE000_0000;
    localparam logic [31:0] ADDR_IO   = 32'hF000_0000;
    localparam logic [31:0] ADDR_CNT  = 32'hF000_0004;
    localparam logic [31:0] ADDR_STAT = 32'hF000_0008;

    logic sel_ram, sel_disp, sel_io, sel_cnt, sel_stat;
    logic [15:0] led_q, led_d;
    logic [31:0] disp_q, disp_d;
    logic [31:0] cnt_rd, stat_rd;
    logic        unused_memrw;

    // MemRW is redundant with |wea; writes are qualified by the lane enables alone.
    assign unused_memrw = bus.MemRW;

    assign sel_ram  = (bus.Addr_out[31:28] == 4'h0);
    assign sel_disp = (bus.Addr_out == ADDR_DISP);
    assign sel_io   = (bus.Addr_out == ADDR_IO);
    assign sel_cnt  = (bus.Addr_out == ADDR_CNT);
    assign sel_stat = (bus.Addr_out == ADDR_STAT);

    assign ram_addr = bus.Addr_out[RAM_ADDR_W+1:2];
    assign ram_wea  = sel_ram ? bus.wea : 4'b0000;
    assign ram_din  = bus.Data_out;

    assign led       = led_q;
    assign disp_data = disp_q;

    // LED and display byte-lane merges
    always_comb begin
        led_d  = led_q;
        disp_d = disp_q;
        if (sel_io) begin
            if (bus.wea[0]) led_d[7:0]  = bus.Data_out[7:0];
            if (bus.wea[1]) led_d[15:8] = bus.Data_out[15:8];
        end
        if (sel_disp) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wea[b]) disp_d[8*b +: 8] = bus.Data_out[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q  <= '0;
            disp_q <= '0;
        end else begin
            led_q  <= led_d;
            disp_q <= disp_d;
        end
    end

`ifdef COUNTER_EN
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [31:0]    cnt_q, cnt_d;
    logic           run_q, run_d;
    logic           done_q, done_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic           irq_q, irq_d;
    logic           tick, cnt_we, stat_we, stop;

    assign cnt_we  = sel_cnt && (|bus.wea);
    assign stat_we = sel_stat && bus.wea[0];
    assign stop    = stat_we && !bus.Data_out[0];
    assign tick    = run_q && (pre_q == PRE_W'(PRESCALE - 1));

    // Priority: CNT load > STAT stop > expiry > STAT start/done-clear
    always_comb begin
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = done_q;
        pre_d  = pre_q;
        irq_d  = 1'b0;
        if (run_q) pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (tick && !stop) begin
            if (cnt_q > 32'd1) begin
                cnt_d = cnt_q - 32'd1;
            end else begin
                cnt_d  = '0;
                run_d  = 1'b0;
                done_d = 1'b1;
                irq_d  = 1'b1;
            end
        end
        if (stat_we) begin
            if (!bus.Data_out[0]) run_d = 1'b0;
            else if (cnt_q != '0 && !irq_d) run_d = 1'b1;
            if (bus.Data_out[1] && !irq_d) done_d = 1'b0;
        end
        if (cnt_we) begin
            cnt_d  = bus.Data_out;
            run_d  = (bus.Data_out != '0);
            done_d = (bus.Data_out == '0);
            pre_d  = '0;
            irq_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            pre_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
            pre_q  <= pre_d;
            irq_q  <= irq_d;
        end
    end

    assign cnt_rd      = cnt_q;
    assign stat_rd     = {30'b0, run_q, done_q};
    assign counter_irq = irq_q;
`else
    assign cnt_rd      = '0;
    assign stat_rd     = '0;
    assign counter_irq = 1'b0;
`endif

    // Zero-latency read mux
    always_comb begin
        bus.Data_in = '0;
        if (sel_ram)       bus.Data_in = ram_dout;
        else if (sel_disp) bus.Data_in = disp_q;
        else if (sel_io)   bus.Data_in = {12'b0, btn, sw};
        else if (sel_cnt)  bus.Data_in = cnt_rd;
        else if (sel_stat) bus.Data_in = stat_rd;
    end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl: vector table for decode/registers, hand sequences for the timer.
module tb_mio_bus_ctrl;

    localparam logic [31:0] A_IO   = 32'hF000_0000;
    localparam logic [31:0] A_CNT  = 32'hF000_0004;
    localparam logic [31:0] A_STAT = 32'hF000_0008;
    localparam logic [31:0] A_DISP = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ram_addr;
    logic [3:0]  ram_wea;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic [15:0] sw;
    logic [3:0]  btn;
    logic [15:0] led;
    logic [31:0] disp_data;
    logic        counter_irq;

    int checks = 0;
    int errors = 0;

    mio_bus_ctrl_if bus ();

    mio_bus_ctrl #(.RAM_ADDR_W(10), .PRESCALE(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ram_addr    (ram_addr),
        .ram_wea     (ram_wea),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .sw          (sw),
        .btn         (btn),
        .led         (led),
        .disp_data   (disp_data),
        .counter_irq (counter_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wea;
        logic [31:0] wdata;
        logic [15:0] sw;
        logic [3:0]  btn;
        logic [31:0] rdout;
        logic [31:0] exp_din;
        logic [3:0]  exp_rwea;
        logic [9:0]  exp_raddr;
        logic [15:0] exp_led;
        logic [31:0] exp_disp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.Addr_out = addr;
        bus.Data_out = data;
        bus.wea      = 4'hF;
        bus.MemRW    = 1'b1;
        cyc();
        bus.wea   = 4'h0;
        bus.MemRW = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.Addr_out = addr;
        bus.wea      = 4'h0;
        bus.MemRW    = 1'b0;
        #1;
        chk(name, bus.Data_in, exp);
    endtask

    initial begin
        vecs[0]  = '{A_IO,          4'h0, 32'h0,         16'h1234, 4'h5, 32'h0,         32'h0005_1234, 4'h0, 10'h000, 16'h0000, 32'h0000_0000};
        vecs[1]  = '{A_DISP,        4'h3, 32'hDEADBEEF,  16'h0,    4'h0, 32'h0,         32'h0000_0000, 4'h0, 10'h000, 16'h0000, 32'h0000_BEEF};
        vecs[2]  = '{A_DISP,        4'hC, 32'hDEADBEEF,  16'h0,    4'h0, 32'h0,         32'h0000_BEEF, 4'h0, 10'h000, 16'h0000, 32'hDEAD_BEEF};
        vecs[3]  = '{A_DISP,        4'h0, 32'h0,         16'h0,    4'h0, 32'h0,         32'hDEAD_BEEF, 4'h0, 10'h000, 16'h0000, 32'hDEAD_BEEF};
        vecs[4]  = '{32'h0000_0010, 4'hF, 32'h11223344,  16'h0,    4'h0, 32'hA5A5A5A5,  32'hA5A5_A5A5, 4'hF, 10'h004, 16'h0000, 32'hDEAD_BEEF};
        vecs[5]  = '{32'h1000_0000, 4'hF, 32'h00000055,  16'h0,    4'h0, 32'h12345678,  32'h0000_0000, 4'h0, 10'h000, 16'h0000, 32'hDEAD_BEEF};
        vecs[6]  = '{A_IO,          4'h1, 32'h0000ABCD,  16'h0,    4'h0, 32'h0,         32'h0000_0000, 4'h0, 10'h000, 16'h00CD, 32'hDEAD_BEEF};
        vecs[7]  = '{A_IO,          4'hE, 32'h12345678,  16'h0,    4'h0, 32'h0,         32'h0000_0000, 4'h0, 10'h000, 16'h56CD, 32'hDEAD_BEEF};
        vecs[8]  = '{A_IO,          4'h0, 32'h0,         16'hFFFF, 4'hF, 32'h0,         32'h000F_FFFF, 4'h0, 10'h000, 16'h56CD, 32'hDEAD_BEEF};
        vecs[9]  = '{32'h0FFF_FFFC, 4'h4, 32'h99887766,  16'h0,    4'h0, 32'hCAFEF00D,  32'hCAFE_F00D, 4'h4, 10'h3FF, 16'h56CD, 32'hDEAD_BEEF};
        vecs[10] = '{32'hE000_0004, 4'hF, 32'h00000000,  16'h0,    4'h0, 32'h0,         32'h0000_0000, 4'h0, 10'h001, 16'h56CD, 32'hDEAD_BEEF};
        vecs[11] = '{32'hF000_000C, 4'hF, 32'h0000FFFF,  16'h0,    4'h0, 32'h0,         32'h0000_0000, 4'h0, 10'h003, 16'h56CD, 32'hDEAD_BEEF};

        rst          = 1'b1;
        bus.MemRW    = 1'b0;
        bus.wea      = 4'h0;
        bus.Addr_out = A_IO;
        bus.Data_out = '0;
        ram_dout     = '0;
        sw           = 16'h1234;
        btn          = 4'h5;
        cyc();
        cyc();
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_disp", disp_data, 32'h0);
        chk("reset_irq", 32'(counter_irq), 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            bus.Addr_out = vecs[i].addr;
            bus.wea      = vecs[i].wea;
            bus.MemRW    = |vecs[i].wea;
            bus.Data_out = vecs[i].wdata;
            sw           = vecs[i].sw;
            btn          = vecs[i].btn;
            ram_dout     = vecs[i].rdout;
            #2;
            chk($sformatf("v%0d_din", i), bus.Data_in, vecs[i].exp_din);
            chk($sformatf("v%0d_ram_wea", i), 32'(ram_wea), 32'(vecs[i].exp_rwea));
            chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].exp_raddr));
            chk($sformatf("v%0d_ram_din", i), ram_din, vecs[i].wdata);
            cyc();
            chk($sformatf("v%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
            chk($sformatf("v%0d_disp", i), disp_data, vecs[i].exp_disp);
        end
        bus.wea   = 4'h0;
        bus.MemRW = 1'b0;

`ifdef COUNTER_EN
        // Load 3: counts 3,2,1,0 with a single irq cycle at zero
        wr(A_CNT, 32'd3);
        rd_chk("a_cnt3", A_CNT, 32'd3);
        chk("a_irq3", 32'(counter_irq), 32'd0);
        for (int n = 2; n >= 0; n--) begin
            cyc();
            rd_chk($sformatf("a_cnt%0d", n), A_CNT, 32'(n));
            chk($sformatf("a_irq%0d", n), 32'(counter_irq), (n == 0) ? 32'd1 : 32'd0);
        end
        cyc();
        chk("a_irq_drop", 32'(counter_irq), 32'd0);
        rd_chk("a_stat_done", A_STAT, 32'd1);
        wr(A_STAT, 32'd2);
        rd_chk("a_stat_clr", A_STAT, 32'd0);

        // Load 5, stop after two ticks, hold, restart
        wr(A_CNT, 32'd5);
        cyc();
        cyc();
        rd_chk("b_cnt3", A_CNT, 32'd3);
        wr(A_STAT, 32'd0);
        rd_chk("b_stop_cnt", A_CNT, 32'd3);
        for (int n = 0; n < 3; n++) begin
            cyc();
            rd_chk($sformatf("b_hold%0d", n), A_CNT, 32'd3);
            chk($sformatf("b_hold_irq%0d", n), 32'(counter_irq), 32'd0);
        end
        rd_chk("b_stat_idle", A_STAT, 32'd0);
        wr(A_STAT, 32'd1);
        rd_chk("b_restart", A_STAT, 32'd2);
        cyc();
        cyc();
        rd_chk("b_cnt1", A_CNT, 32'd1);
        chk("b_irq_early", 32'(counter_irq), 32'd0);
        cyc();
        rd_chk("b_cnt0", A_CNT, 32'd0);
        chk("b_irq", 32'(counter_irq), 32'd1);
        rd_chk("b_stat", A_STAT, 32'd1);

        // CNT write in the expiry cycle wins
        wr(A_CNT, 32'd1);
        wr(A_CNT, 32'd2);
        rd_chk("c_cnt2", A_CNT, 32'd2);
        chk("c_no_irq", 32'(counter_irq), 32'd0);
        rd_chk("c_stat", A_STAT, 32'd2);
        cyc();
        cyc();
        chk("c_irq", 32'(counter_irq), 32'd1);

        // Done-clear in the expiry cycle loses to the set
        wr(A_CNT, 32'd2);
        cyc();
        wr(A_STAT, 32'd3);
        chk("d_irq", 32'(counter_irq), 32'd1);
        rd_chk("d_stat", A_STAT, 32'd1);
        rd_chk("d_cnt", A_CNT, 32'd0);

        // Reset mid-count aborts without irq
        wr(A_CNT, 32'd5);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        rd_chk("e_cnt", A_CNT, 32'd0);
        rd_chk("e_stat", A_STAT, 32'd0);
        chk("e_led", 32'(led), 32'd0);
        for (int n = 0; n < 6; n++) begin
            cyc();
            chk($sformatf("e_irq%0d", n), 32'(counter_irq), 32'd0);
        end
`else
        // Timer absent: CNT/STAT read zero, irq never fires
        wr(A_CNT, 32'd7);
        rd_chk("n_cnt", A_CNT, 32'd0);
        wr(A_STAT, 32'd1);
        rd_chk("n_stat", A_STAT, 32'd0);
        for (int n = 0; n < 8; n++) begin
            cyc();
            chk($sformatf("n_irq%0d", n), 32'(counter_irq), 32'd0);
        end
        rd_chk("n_cnt_late", A_CNT, 32'd0);
        rd_chk("n_disp_kept", A_DISP, 32'hDEAD_BEEF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mio_bus_ctrl.md
# mio_bus_ctrl

Memory-mapped I/O bus controller on the data side of the pipelined CPU, directly downstream of its MEM stage. It consumes the CPU's data address, lane-aligned store data and byte write-enables. It returns read data on the CPU's data input in the same cycle. It decodes each access to data RAM, the LED/switch port, the 7-segment display register or a down-counter timer.

## Interface
Parameters:
- RAM_ADDR_W, 10, RAM word-address width (RAM spans 4·2^RAM_ADDR_W bytes)
- PRESCALE, 1, clock cycles per timer decrement (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- MemRW  in  1  store in MEM stage (OR of wea)
- wea  in  4  byte write-enables, already shifted to lane
- Addr_out  in  32  byte address from MEM stage
- Data_out  in  32  store data, already lane-aligned
- Data_in  out  32  read data to CPU, combinational
- ram_addr  out  RAM_ADDR_W  word address = Addr_out[RAM_ADDR_W+1:2]
- ram_wea  out  4  wea gated by RAM select
- ram_din  out  32  = Data_out
- ram_dout  in  32  asynchronous-read RAM data
- sw  in  16  switches
- btn  in  4  buttons
- led  out  16  LED register
- disp_data  out  32  7-segment display register
- counter_irq  out  1  one-cycle pulse on timer expiry

## Operation
Address decode:
- Addr_out[31:28]=0x0 → RAM.
- 0xE000_0000 → DISP.
- 0xF000_0000 → IO.
- 0xF000_0004 → CNT.
- 0xF000_0008 → STAT.
- Any other address → read 0, write ignored; ram_wea=0 unless RAM is selected.

Registers:
- IO read: {12'b0, btn, sw}. IO write: led updated per byte lane, from wea[1:0] only.
- DISP: read/write, per-byte merge under wea.
- CNT read: current count. CNT write (any wea bit set): count ← Data_out (full word); running ← (Data_out≠0); done ← (Data_out==0); prescaler cleared.
- STAT read: {30'b0, running, done}. STAT write, lane 0 enabled:
  - bit0=0 → running←0.
  - bit0=1 with count≠0 → running←1.
  - bit1=1 → done←0.

Timer:
- tick = running && prescaler==PRESCALE-1. The prescaler counts only while running and wraps to 0 on tick.
- On tick with count>1: count−1.
- On tick with count==1: count←0, running←0, done←1, counter_irq←1 for exactly one cycle.
- count never wraps below 0.

Simultaneous events:
- CNT write in the expiry cycle: the write wins; no done, no irq.
- STAT done-clear in the expiry cycle: the set wins (done=1, irq pulses).
- STAT stop in the expiry cycle: the stop wins; count unchanged, no irq.

## Timing
- Reads have zero latency: Data_in is a combinational mux of Addr_out and the register/RAM values.
- Writes commit at the rising edge where wea≠0. Read-back is visible from the next cycle.
- counter_irq is registered. It goes high the cycle after the expiring edge's decision, coincident with done=1.
- With PRESCALE=1 and load N at edge k: count reaches 0 and irq is high after edge k+N.
- Reset values at the first rising edge with rst=1: led=0, disp_data=0, count=0, running=0, done=0, prescaler=0, counter_irq=0.
- Reset mid-count aborts the count; no irq is emitted.
- RAM and combinational outputs follow their inputs during reset. ram_wea is not forced to 0.

## Configuration
- COUNTER_EN defined: timer (CNT, STAT, counter_irq) present as above.
- COUNTER_EN undefined: timer logic removed. CNT and STAT read 0; writes to them are ignored; counter_irq tied 0. RAM, IO and DISP behaviour is unchanged.

## Test plan
- Reset, then read 0xF000_0000 with sw=0x1234, btn=0x5 → Data_in=0x0005_1234; led=0, disp_data=0.
- Write 0xDEADBEEF to 0xE000_0000 with wea=0011 over prior 0 → disp_data=0x0000_BEEF next cycle. Then wea=1100 with 0xDEADBEEF → disp_data=0xDEAD_BEEF.
- RAM access at 0x0000_0010 with wea=1111 → ram_addr=4, ram_wea=1111. Access at 0x1000_0000 → ram_wea=0000, read returns 0.
- PRESCALE=1, write 3 to CNT → count reads 2,1,0 on the following cycles; counter_irq high for exactly one cycle; STAT reads 0b01. Write 2 to STAT → STAT reads 0.
- Load 5, stop via STAT=0 after 2 ticks → count holds 3, no irq. Then STAT=1 → expiry 3 ticks later.
- Build without COUNTER_EN, write 7 to CNT → CNT reads 0, counter_irq stays 0.
